// File: rtl/prng_reject_sampler.sv
// Galois-LFSR random source with rejection sampling against an inclusive limit
// and a set of exclude slots, returning one result per request over valid/ready.
//
// state | meaning
// IDLE  | waiting for req; seed_load honoured here only
// STEP  | advance the LFSR once to produce the next candidate
// CHECK | evaluate candidate, accept / give up / retry
// HOLD  | result presented, waiting for ready
module prng_reject_sampler #(
  parameter int                   OUTPUT_SIZE = 4,
  parameter int                   LFSR_SIZE   = 16,
  parameter logic [LFSR_SIZE-1:0] TAPS        = 16'hB400,
  parameter int                   NUM_EXCLUDE = 2,
  parameter int                   MAX_TRIES   = 15
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [LFSR_SIZE-1:0]               seed,
  input  logic                               seed_load,
  input  logic                               req,
  input  logic [OUTPUT_SIZE-1:0]             limit,
  input  logic [NUM_EXCLUDE*OUTPUT_SIZE-1:0] exclude_vec,
  input  logic [NUM_EXCLUDE-1:0]             exclude_en,
  input  logic                               ready,
  output logic                               valid,
  output logic [OUTPUT_SIZE-1:0]             rnd,
  output logic                               fail,
  output logic                               busy,
  output logic [$clog2(MAX_TRIES+2)-1:0]     tries
);

  localparam int TW = $clog2(MAX_TRIES+2);
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES);
  localparam logic [TW-1:0] TRIES_SAT  = TW'(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, STEP, CHECK, HOLD} state_t;

  state_t state, state_nxt;

  logic [LFSR_SIZE-1:0]               lfsr;
  logic [LFSR_SIZE-1:0]               lfsr_step;
  logic [LFSR_SIZE-1:0]               seed_safe;
  logic [OUTPUT_SIZE-1:0]             cand;
  logic [OUTPUT_SIZE-1:0]             limit_q;
  logic [NUM_EXCLUDE*OUTPUT_SIZE-1:0] excl_q;
  logic [NUM_EXCLUDE-1:0]             excl_en_q;
  logic                               excl_hit;
  logic                               accept;
  logic                               give_up;

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1.
  assign seed_safe = (seed == '0) ? LFSR_SIZE'(1) : seed;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign cand      = lfsr[OUTPUT_SIZE-1:0];

  always_comb begin
    excl_hit = 1'b0;
    for (int i = 0; i < NUM_EXCLUDE; i++) begin
      if (excl_en_q[i] && (excl_q[i*OUTPUT_SIZE +: OUTPUT_SIZE] == cand)) excl_hit = 1'b1;
    end
  end

  assign accept  = (cand <= limit_q) && !excl_hit;
  assign give_up = !accept && (tries == TRIES_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = STEP;
      STEP:    state_nxt = CHECK;
      CHECK:   state_nxt = (accept || give_up) ? HOLD : STEP;
      HOLD:    if (ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == HOLD);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr      <= seed_safe;
      rnd       <= '0;
      fail      <= 1'b0;
      tries     <= '0;
      limit_q   <= '0;
      excl_q    <= '0;
      excl_en_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= seed_safe;
          if (req) begin
            limit_q   <= limit;
            excl_q    <= exclude_vec;
            excl_en_q <= exclude_en;
            tries     <= '0;
          end
        end
        STEP: lfsr <= lfsr_step;
        CHECK: begin
          tries <= (tries == TRIES_SAT) ? tries : tries + 1'b1;
          if (accept) begin
            rnd  <= cand;
            fail <= 1'b0;
          end else if (give_up) begin
            rnd  <= '0;
            fail <= 1'b1;
          end
        end
        HOLD: if (ready) fail <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
